// File: rtl/psram_port_arbiter.sv
// Two-port arbiter in front of the byte-wide PSRAM wrapper: cart fetch path (A, read-only,
// high priority) and loader/debug path (B, read/write) with a starvation guard and timeout.
module psram_port_arbiter #(
    parameter int MAX_A_STREAK = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_req,
    input  logic [21:0] a_addr,
    output logic [7:0]  a_rdata,
    output logic        a_done,
    input  logic        b_req,
    input  logic        b_write,
    input  logic [21:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic [7:0]  b_rdata,
    output logic        b_done,
    output logic        timeout_err,
    output logic        mem_cmd_valid,
    output logic        mem_cmd_write,
    output logic [21:0] mem_cmd_addr,
    output logic [7:0]  mem_write_data,
    input  logic [7:0]  mem_read_data,
    input  logic        mem_data_ready,
    input  logic        mem_busy
);
    // state | meaning
    // IDLE  | waiting for a request while the wrapper is not busy
    // ISSUE | command strobe to the wrapper (one cycle)
    // WAIT  | waiting for mem_data_ready or timer expiry
    // DONE  | completion pulse to the owner; requests not sampled
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [7:0] STREAK_MAX = 8'(MAX_A_STREAK);
    localparam logic [9:0] TMR_LOAD   = 10'(TIMEOUT);

    state_t      state;
    logic        owner_b;
    logic [7:0]  streak;
    logic [9:0]  tmr;
    logic        grant_b;

    assign grant_b = b_req && ((streak == STREAK_MAX) || !a_req);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            owner_b        <= 1'b0;
            streak         <= 8'd0;
            tmr            <= 10'd0;
            a_rdata        <= 8'd0;
            a_done         <= 1'b0;
            b_rdata        <= 8'd0;
            b_done         <= 1'b0;
            timeout_err    <= 1'b0;
            mem_cmd_valid  <= 1'b0;
            mem_cmd_write  <= 1'b0;
            mem_cmd_addr   <= 22'd0;
            mem_write_data <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if ((a_req || b_req) && !mem_busy) begin
                        if (grant_b) begin
                            owner_b        <= 1'b1;
                            mem_cmd_write  <= b_write;
                            mem_cmd_addr   <= b_addr;
                            mem_write_data <= b_wdata;
                            streak         <= 8'd0;
                        end else begin
                            owner_b        <= 1'b0;
                            mem_cmd_write  <= 1'b0;
                            mem_cmd_addr   <= a_addr;
                            mem_write_data <= 8'd0;
                            if (!b_req)
                                streak <= 8'd0;
                            else if (streak != STREAK_MAX)
                                streak <= streak + 8'd1;
                        end
                        mem_cmd_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_cmd_valid <= 1'b0;
                    tmr           <= TMR_LOAD;
                    state         <= WAIT;
                end
                WAIT: begin
                    if (mem_data_ready) begin
                        if (!mem_cmd_write) begin
                            if (owner_b) b_rdata <= mem_read_data;
                            else         a_rdata <= mem_read_data;
                        end
                        a_done <= !owner_b;
                        b_done <= owner_b;
                        state  <= DONE;
                    end else if (tmr == 10'd0) begin
                        // Abort: reads return all-ones so the requester sees an obvious bad byte
                        timeout_err <= 1'b1;
                        if (!mem_cmd_write) begin
                            if (owner_b) b_rdata <= 8'hFF;
                            else         a_rdata <= 8'hFF;
                        end
                        a_done <= !owner_b;
                        b_done <= owner_b;
                        state  <= DONE;
                    end else begin
                        tmr <= tmr - 10'd1;
                    end
                end
                DONE: begin
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psram_port_arbiter.sv
// Directed bench for psram_port_arbiter with a small PSRAM wrapper responder model.
module tb_psram_port_arbiter;
    localparam int MAX_A_STREAK = 8;
    localparam int TIMEOUT      = 64;

    logic        clk;
    logic        reset_n;
    logic        a_req;
    logic [21:0] a_addr;
    logic [7:0]  a_rdata;
    logic        a_done;
    logic        b_req;
    logic        b_write;
    logic [21:0] b_addr;
    logic [7:0]  b_wdata;
    logic [7:0]  b_rdata;
    logic        b_done;
    logic        timeout_err;
    logic        mem_cmd_valid;
    logic        mem_cmd_write;
    logic [21:0] mem_cmd_addr;
    logic [7:0]  mem_write_data;
    logic [7:0]  mem_read_data;
    logic        mem_data_ready;
    logic        mem_busy;

    int n_checks = 0;
    int n_fail   = 0;

    bit         resp_on    = 1'b0;
    int         resp_delay = 1;
    logic [7:0] resp_data  = 8'h00;
    int         kick_req   = 0;

    psram_port_arbiter #(.MAX_A_STREAK(MAX_A_STREAK), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_addr(a_addr), .a_rdata(a_rdata), .a_done(a_done),
        .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_done(b_done), .timeout_err(timeout_err),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_write(mem_cmd_write),
        .mem_cmd_addr(mem_cmd_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_data_ready(mem_data_ready),
        .mem_busy(mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wrapper responder: answers a seen command after resp_delay cycles; kick_req forces a stray pulse
    initial begin
        bit pend;
        int cnt;
        int kick_seen;
        pend = 1'b0;
        cnt = 0;
        kick_seen = 0;
        mem_data_ready = 1'b0;
        mem_read_data  = 8'h00;
        forever begin
            @(negedge clk);
            mem_data_ready = 1'b0;
            if (!reset_n) begin
                pend = 1'b0;
            end else if (kick_req != kick_seen) begin
                kick_seen      = kick_req;
                mem_data_ready = 1'b1;
                mem_read_data  = 8'h11;
            end else if (pend) begin
                if (cnt <= 1) begin
                    mem_data_ready = 1'b1;
                    mem_read_data  = resp_data;
                    pend           = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (mem_cmd_valid && resp_on) begin
                pend = 1'b1;
                cnt  = resp_delay;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        a_req    = 1'b0;
        a_addr   = 22'd0;
        b_req    = 1'b0;
        b_write  = 1'b0;
        b_addr   = 22'd0;
        b_wdata  = 8'd0;
        mem_busy = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_write_data} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mem_cmd: got %h required 0",
                     {mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_write_data});
        end
        n_checks++;
        if ({a_rdata, b_rdata, a_done, b_done, timeout_err} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {a_rdata, b_rdata, a_done, b_done, timeout_err});
        end
        reset_n = 1'b1;
        repeat (2) step();
        n_checks++;
        if (mem_cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_no_cmd: got %b required 0", mem_cmd_valid);
        end
    endtask

    task automatic test_a_read();
        int nv = 0, nad = 0, nbd = 0, vstep = -1;
        logic wr = 1'bx;
        logic [21:0] ad = 'x;
        bit got = 1'b0;
        resp_on    = 1'b1;
        resp_delay = 6;
        resp_data  = 8'h5A;
        a_addr     = 22'h000123;
        a_req      = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (mem_cmd_valid) begin
                nv++;
                wr = mem_cmd_write;
                ad = mem_cmd_addr;
                if (vstep < 0) vstep = i + 1;
            end
            if (b_done) nbd++;
            if (a_done) begin
                nad++;
                got = 1'b1;
                a_req = 1'b0;
                n_checks++;
                if (a_rdata !== 8'h5A) begin
                    n_fail++;
                    $display("FAIL a_read_rdata: got %h required 5a", a_rdata);
                end
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL a_read_done_seen: got no a_done required one within 40 cycles");
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_cmd_valid) nv++;
            if (a_done) nad++;
            if (b_done) nbd++;
        end
        n_checks++;
        if (nv !== 1) begin n_fail++; $display("FAIL a_read_valid_count: got %0d required 1", nv); end
        n_checks++;
        if (vstep < 1 || vstep > 2) begin n_fail++; $display("FAIL a_read_issue_latency: got %0d required 1..2", vstep); end
        n_checks++;
        if (wr !== 1'b0) begin n_fail++; $display("FAIL a_read_cmd_write: got %b required 0", wr); end
        n_checks++;
        if (ad !== 22'h000123) begin n_fail++; $display("FAIL a_read_cmd_addr: got %h required 000123", ad); end
        n_checks++;
        if (nad !== 1) begin n_fail++; $display("FAIL a_read_done_count: got %0d required 1", nad); end
        n_checks++;
        if (nbd !== 0) begin n_fail++; $display("FAIL a_read_b_done: got %0d required 0", nbd); end
    endtask

    task automatic test_b_read_write();
        int nbd = 0, nad = 0;
        bit got = 1'b0;
        logic wr = 1'bx;
        logic [21:0] ad = 'x;
        logic [7:0] wd = 'x;
        resp_on    = 1'b1;
        resp_delay = 3;
        resp_data  = 8'h3C;
        b_write    = 1'b0;
        b_addr     = 22'h000456;
        b_req      = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (b_done) begin got = 1'b1; b_req = 1'b0; end
        end
        n_checks++;
        if (!got || b_rdata !== 8'h3C) begin
            n_fail++;
            $display("FAIL b_read_rdata: got %h (done %b) required 3c", b_rdata, got);
        end
        step();
        got        = 1'b0;
        resp_data  = 8'h99;
        b_write    = 1'b1;
        b_addr     = 22'h3FFFFF;
        b_wdata    = 8'hC3;
        b_req      = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (mem_cmd_valid) begin wr = mem_cmd_write; ad = mem_cmd_addr; wd = mem_write_data; end
            if (a_done) nad++;
            if (b_done) begin nbd++; got = 1'b1; b_req = 1'b0; end
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (b_done) nbd++;
            if (a_done) nad++;
        end
        n_checks++;
        if (wr !== 1'b1) begin n_fail++; $display("FAIL b_write_cmd_write: got %b required 1", wr); end
        n_checks++;
        if (ad !== 22'h3FFFFF) begin n_fail++; $display("FAIL b_write_cmd_addr: got %h required 3fffff", ad); end
        n_checks++;
        if (wd !== 8'hC3) begin n_fail++; $display("FAIL b_write_wdata: got %h required c3", wd); end
        n_checks++;
        if (nbd !== 1) begin n_fail++; $display("FAIL b_write_done_count: got %0d required 1", nbd); end
        n_checks++;
        if (b_rdata !== 8'h3C) begin n_fail++; $display("FAIL b_write_rdata_kept: got %h required 3c", b_rdata); end
        n_checks++;
        if (nad !== 0) begin n_fail++; $display("FAIL b_write_a_done: got %0d required 0", nad); end
        b_write = 1'b0;
    endtask

    task automatic test_streak();
        bit glog[$];
        bit got = 1'b0;
        int nv = 0;
        resp_on    = 1'b1;
        resp_delay = 1;
        resp_data  = 8'h00;
        a_addr     = 22'h000A00;
        b_addr     = 22'h00B000;
        b_write    = 1'b0;
        a_req      = 1'b1;
        b_req      = 1'b1;
        for (int i = 0; i < 400 && glog.size() < 18; i++) begin
            step();
            if (mem_cmd_valid) glog.push_back(mem_cmd_addr == 22'h00B000);
        end
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (a_done || b_done) begin got = 1'b1; a_req = 1'b0; b_req = 1'b0; end
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (mem_cmd_valid) nv++;
        end
        n_checks++;
        if (glog.size() !== 18 || !got) begin
            n_fail++;
            $display("FAIL streak_grant_count: got %0d grants (final done %b) required 18", glog.size(), got);
        end else begin
            for (int i = 0; i < 18; i++) begin
                n_checks++;
                if (glog[i] !== (i == 8 || i == 17)) begin
                    n_fail++;
                    $display("FAIL streak_order[%0d]: got B=%b required B=%b", i, glog[i], (i == 8 || i == 17));
                end
            end
        end
        n_checks++;
        if (nv !== 0) begin n_fail++; $display("FAIL streak_no_regrant: got %0d commands required 0", nv); end
    endtask

    task automatic test_timeout();
        int vstep = -1, dstep = -1, nad = 0;
        resp_on = 1'b0;
        a_addr  = 22'h000777;
        a_req   = 1'b1;
        for (int i = 0; i < 120 && dstep < 0; i++) begin
            step();
            if (mem_cmd_valid && vstep < 0) vstep = i;
            if (a_done) begin nad++; dstep = i; a_req = 1'b0; end
        end
        n_checks++;
        if (vstep < 0 || dstep - vstep !== TIMEOUT + 2) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles (issue %0d done %0d) required %0d",
                     dstep - vstep, vstep, dstep, TIMEOUT + 2);
        end
        n_checks++;
        if (a_rdata !== 8'hFF) begin n_fail++; $display("FAIL timeout_rdata: got %h required ff", a_rdata); end
        n_checks++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %b required 1", timeout_err); end
        step();
        kick_req++;
        for (int i = 0; i < 6; i++) begin
            step();
            if (a_done || b_done) nad++;
        end
        n_checks++;
        if (nad !== 1) begin n_fail++; $display("FAIL timeout_late_ready_done: got %0d done pulses required 1", nad); end
        n_checks++;
        if (a_rdata !== 8'hFF) begin n_fail++; $display("FAIL timeout_late_ready_rdata: got %h required ff", a_rdata); end
        n_checks++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b required 1", timeout_err); end
    endtask

    task automatic test_busy();
        int nv = 0, vstep = -1;
        bit got = 1'b0;
        resp_on    = 1'b1;
        resp_delay = 2;
        resp_data  = 8'h42;
        mem_busy   = 1'b1;
        a_addr     = 22'h001000;
        a_req      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_cmd_valid) nv++;
        end
        n_checks++;
        if (nv !== 0) begin n_fail++; $display("FAIL busy_blocks_grant: got %0d commands required 0", nv); end
        mem_busy = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (mem_cmd_valid && vstep < 0) vstep = i + 1;
            if (a_done) begin got = 1'b1; a_req = 1'b0; end
        end
        n_checks++;
        if (vstep < 1 || vstep > 2) begin n_fail++; $display("FAIL busy_release_issue: got %0d cycles required 1..2", vstep); end
        n_checks++;
        if (!got || a_rdata !== 8'h42) begin
            n_fail++;
            $display("FAIL busy_read_rdata: got %h (done %b) required 42", a_rdata, got);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int nad = 0;
        bit seen = 1'b0;
        bit got = 1'b0;
        resp_on = 1'b0;
        a_addr  = 22'h002000;
        a_req   = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (mem_cmd_valid) seen = 1'b1;
        end
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_write_data, a_rdata, b_rdata,
             a_done, b_done, timeout_err} !== 51'd0 || !seen) begin
            n_fail++;
            $display("FAIL reset_mid_async_outputs: got cmd_addr %h rdata %h err %b (issued %b) required all 0",
                     mem_cmd_addr, a_rdata, timeout_err, seen);
        end
        a_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (a_done || b_done) nad++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (a_done || b_done || mem_cmd_valid) nad++;
        end
        n_checks++;
        if (nad !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d events required 0", nad); end
        resp_on    = 1'b1;
        resp_delay = 4;
        resp_data  = 8'h7E;
        a_addr     = 22'h002001;
        a_req      = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (a_done) begin got = 1'b1; a_req = 1'b0; end
        end
        n_checks++;
        if (!got || a_rdata !== 8'h7E) begin
            n_fail++;
            $display("FAIL reset_mid_fresh_read: got %h (done %b) required 7e", a_rdata, got);
        end
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_mid_err_clear: got %b required 0", timeout_err); end
    endtask

    initial begin
        test_reset();
        test_a_read();
        test_b_read_write();
        test_streak();
        test_timeout();
        test_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
